// File: rtl/prog_seqdet_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// Holds the control FSM states, the length clamp and the default sizes.
package prog_seqdet_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_COUNT_W = 8;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        HUNT  = 2'd2
    } seq_state_e;

    // Lengths above the history depth are treated as the full depth.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// When clear and increment coincide, the counter restarts at 1.
module sat_counter
    import prog_seqdet_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr) begin
            count_d = inc ? COUNT_W'(1) : '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/prog_sequence_detector.sv
// Runtime-programmable serial sequence detector with overlapping or
// non-overlapping matching, a registered match pulse and a saturating count.
module prog_sequence_detector
    import prog_seqdet_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [COUNT_W-1:0] match_count,
    output logic               armed
);

    seq_state_e         state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               out_q;
    // The oldest history bit can never fall inside a compare window, so it is not stored.
    logic [MAX_LEN-2:0] hist_q;
    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;

    logic [LEN_W-1:0]   cfg_len_clamped;
    logic [MAX_LEN-1:0] len_mask;
    logic               bit_acc;
    logic               match_hit;

    assign cfg_len_clamped = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
    assign armed           = (state_q != UNCFG);
    assign bit_acc         = in_valid && !cfg_load;
    assign hist_d          = {hist_q, in};

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // armed guarantees len_q >= 1, so len_q - 1 cannot wrap here.
    assign match_hit = armed && bit_acc
                    && (fill_q >= (len_q - LEN_W'(1)))
                    && ((hist_d & len_mask) == (pat_q & len_mask));

    always_comb begin
        fill_d = fill_q;
        if (match_hit && !ovl_q) begin
            fill_d = '0;
        end else if (fill_q < len_q) begin
            fill_d = fill_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            out_q   <= 1'b0;
        end else begin
            out_q <= match_hit;
            if (cfg_load) begin
                pat_q   <= cfg_pattern;
                len_q   <= cfg_len_clamped;
                ovl_q   <= cfg_overlap;
                hist_q  <= '0;
                fill_q  <= '0;
                state_q <= (cfg_len_clamped != '0) ? FILL : UNCFG;
            end else if (in_valid) begin
                hist_q <= hist_d[MAX_LEN-2:0];
                fill_q <= fill_d;
                case (state_q)
                    FILL: begin
                        if (!(match_hit && !ovl_q) && (fill_q == (len_q - LEN_W'(1)))) begin
                            state_q <= HUNT;
                        end
                    end
                    HUNT: begin
                        if (match_hit && !ovl_q) begin
                            state_q <= FILL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_hit),
        .clr   (cnt_clr),
        .count (match_count)
    );

    assign out = out_q;

endmodule

// File: tb/tb_prog_sequence_detector.sv
// Bench for prog_sequence_detector: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a bit-queue reference model.
module tb_prog_sequence_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       out_a, armed_a;
    logic [7:0] cnt_a;
    logic       out_b, armed_b;
    logic [1:0] cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    prog_sequence_detector #(.MAX_LEN(8), .COUNT_W(8)) dut (
        .clk(clk), .reset(rst_n), .in(din), .in_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out_a), .match_count(cnt_a), .armed(armed_a)
    );

    prog_sequence_detector #(.MAX_LEN(8), .COUNT_W(2)) dut_c2 (
        .clk(clk), .reset(rst_n), .in(din), .in_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out_b), .match_count(cnt_b), .armed(armed_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: the accepted bits since the last load, newest at the back,
    // and the number of fresh bits available since the load or last non-overlap match.
    int         m_len = 0;
    logic [7:0] m_pat = '0;
    bit         m_ovl = 1'b0;
    bit         m_bits[$];
    int         m_fresh = 0;
    bit         exp_out = 1'b0;
    int         exp_cnt8 = 0;
    int         exp_cnt2 = 0;
    bit         exp_armed = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit hit;
        hit = 1'b0;
        if (!rst_n) begin
            m_len = 0; m_pat = '0; m_ovl = 1'b0; m_bits.delete(); m_fresh = 0;
            exp_cnt8 = 0; exp_cnt2 = 0;
        end else begin
            if (cfg_load) begin
                m_len = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
                m_pat = cfg_pattern;
                m_ovl = cfg_overlap;
                m_bits.delete();
                m_fresh = 0;
            end else if (din_valid) begin
                m_bits.push_back(din);
                if (m_bits.size() > 8) void'(m_bits.pop_front());
                m_fresh++;
                if (m_len > 0 && m_fresh >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++) begin
                        if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                    end
                end
                if (hit && !m_ovl) m_fresh = 0;
            end
            if (cnt_clr) begin
                exp_cnt8 = hit ? 1 : 0;
                exp_cnt2 = hit ? 1 : 0;
            end else if (hit) begin
                if (exp_cnt8 < 255) exp_cnt8++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
        exp_out   = hit;
        exp_armed = (m_len != 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_a", int'(out_a), int'(exp_out));
            check("cnt_a", int'(cnt_a), exp_cnt8);
            check("armed_a", int'(armed_a), int'(exp_armed));
            check("out_b", int'(out_b), int'(exp_out));
            check("cnt_b", int'(cnt_b), exp_cnt2);
            check("armed_b", int'(armed_b), int'(exp_armed));
        end
    end

    // Called just after a falling edge; returns just after the next one.
    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic b = 1'b0, input logic v = 1'b0);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_load = 1'b1;
        din = b; din_valid = v;
        @(negedge clk);
        cfg_load = 1'b0; din_valid = 1'b0;
    endtask

    // '1'/'0' feed a valid bit, '-' is an idle cycle; pulses gives the out value after each cycle.
    task automatic feed(input string bits, input string pulses, input string name);
        for (int i = 0; i < bits.len(); i++) begin
            din_valid = (bits[i] != "-");
            din       = (bits[i] == "1");
            @(negedge clk);
            check($sformatf("%s_out%0d", name, i), int'(out_a), (pulses[i] == "1") ? 1 : 0);
        end
        din_valid = 1'b0;
    endtask

    task automatic clear_count();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", int'(out_a), 0);
        check("rst_cnt", int'(cnt_a), 0);
        check("rst_armed", int'(armed_a), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Overlapping 1101: pulses after bits 4 and 7.
        load(8'b0000_1101, 4'd4, 1'b1);
        check("basic_armed", int'(armed_a), 1);
        feed("1101101", "0001001", "basic");
        check("basic_cnt", int'(cnt_a), 2);
        clear_count();
        check("clr_cnt", int'(cnt_a), 0);

        // Pattern 11, non-overlapping then overlapping.
        load(8'b0000_0011, 4'd2, 1'b0);
        feed("1111", "0101", "novl");
        check("novl_cnt", int'(cnt_a), 2);
        clear_count();
        load(8'b0000_0011, 4'd2, 1'b1);
        feed("1111", "0111", "ovl");
        check("ovl_cnt", int'(cnt_a), 3);
        check("ovl_cnt_sat2", int'(cnt_b), 3);
        clear_count();

        // Idle cycles between bits do not disturb the window.
        load(8'b0000_0101, 4'd3, 1'b0);
        feed("1--0-1-", "0000010", "gaps");
        check("gaps_cnt", int'(cnt_a), 1);

        // A bit offered alongside cfg_load is dropped; a reload clears partial history.
        load(8'b0000_0101, 4'd3, 1'b0, 1'b1, 1'b1);
        feed("01", "00", "ldbit");
        feed("01", "01", "ldbit2");
        feed("10", "00", "partial");
        load(8'b0000_0101, 4'd3, 1'b0);
        feed("1", "0", "reload");
        feed("01", "01", "reload2");

        // Length 0 disarms; length 15 is clamped to 8.
        load(8'hFF, 4'd0, 1'b1);
        check("len0_armed", int'(armed_a), 0);
        feed("11111111", "00000000", "len0");
        load(8'hA5, 4'd15, 1'b1);
        check("len15_armed", int'(armed_a), 1);
        feed("10100101", "00000001", "len15");

        // Saturation of the 2-bit counter and clear coincident with a match.
        clear_count();
        load(8'b0000_0001, 4'd1, 1'b1);
        feed("11111", "11111", "sat");
        check("sat_cnt8", int'(cnt_a), 5);
        check("sat_cnt2", int'(cnt_b), 3);
        cnt_clr = 1'b1; din = 1'b1; din_valid = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0; din_valid = 1'b0;
        check("clrhit_out", int'(out_a), 1);
        check("clrhit_cnt8", int'(cnt_a), 1);
        check("clrhit_cnt2", int'(cnt_b), 1);

        // Reset after three of four matching bits.
        load(8'b0000_1101, 4'd4, 1'b0);
        feed("110", "000", "pre_rst");
        pulse_reset();
        check("mid_rst_out", int'(out_a), 0);
        check("mid_rst_cnt", int'(cnt_a), 0);
        check("mid_rst_armed", int'(armed_a), 0);
        feed("1", "0", "unarmed");
        load(8'b0000_1101, 4'd4, 1'b0);
        feed("1101", "0001", "post_rst");
        check("post_rst_cnt", int'(cnt_a), 1);

        // Randomized traffic, checked by the per-cycle compare process.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                cfg_load = ($urandom_range(0, 39) == 0);
                if (cfg_load) begin
                    cfg_pattern = 8'($urandom);
                    cfg_overlap = 1'($urandom);
                    cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                              : 4'($urandom_range(1, 4));
                end
                din       = 1'($urandom);
                din_valid = ($urandom_range(0, 3) != 0);
                cnt_clr   = ($urandom_range(0, 49) == 0);
                @(negedge clk);
            end
        end
        cfg_load = 1'b0; din_valid = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
